// File: rtl/game_pkg.sv
// +----------------------------------------------------------------------+
// | game_pkg: shared state encoding for the factorization game blocks.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package game_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 4'b0001;
    localparam logic [STATE_W-1:0] ST_READY  = 4'b0010;
    localparam logic [STATE_W-1:0] ST_PLAY   = 4'b0100;
    localparam logic [STATE_W-1:0] ST_RESULT = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// +----------------------------------------------------------------------+
// | dwell_timer: counts cycles while running, pulses o_done on the cycle |
// | the count reaches TERMINAL-1. Revision: 1.0                          |
// +----------------------------------------------------------------------+
`default_nettype none

module dwell_timer #(
    parameter int TERMINAL = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_done
);

    localparam int              CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_done = i_run && (cnt_q == LAST);

    // Restart from zero after done so a back-to-back entry sees a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_done) begin
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_state_ctrl.sv
// +----------------------------------------------------------------------+
// | game_state_ctrl: master sequencer (IDLE/READY/PLAY/RESULT), rounds   |
// | and scores. Optional macro PLAY_TIMEOUT_EN bounds PLAY. Rev: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module game_state_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS        = 5,
    parameter int RESULT_CYCLES = 1024,
    parameter int PLAY_TIMEOUT  = 65536,
    parameter int SCORE_W       = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               OK,
    input  logic               OK_2,
    input  logic               WIN_1P,
    input  logic               WIN_2P,
    output logic [STATE_W-1:0] STATE,
    output logic [3:0]         ROUND,
    output logic [SCORE_W-1:0] SCORE_1P,
    output logic [SCORE_W-1:0] SCORE_2P,
    output logic               GAME_OVER,
    output logic               LED
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               start_q;
    logic               ok1_q, ok1_d;
    logic               ok2_q, ok2_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               game_over_q, game_over_d;
    logic               led_q, led_d;

    logic w_start_rise;
    logic w_ready_go;
    logic w_any_win;
    logic w_result_done;
    logic w_play_timeout;
    logic w_last_round;

    assign w_start_rise = START && !start_q;
    // Current-cycle inputs count alongside the sticky flags, giving one-cycle latency.
    assign w_ready_go   = (ok1_q || OK) && (ok2_q || OK_2);
    assign w_any_win    = WIN_1P || WIN_2P;
    assign w_last_round = (round_q >= 4'(ROUNDS));

    dwell_timer #(
        .TERMINAL (RESULT_CYCLES)
    ) u_result_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .i_clear (state_q != ST_RESULT),
        .i_run   (state_q == ST_RESULT),
        .o_done  (w_result_done)
    );

`ifdef PLAY_TIMEOUT_EN
    dwell_timer #(
        .TERMINAL (PLAY_TIMEOUT)
    ) u_play_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .i_clear (state_q != ST_PLAY),
        .i_run   (state_q == ST_PLAY),
        .o_done  (w_play_timeout)
    );
`else
    logic w_unused_play_timeout;
    assign w_unused_play_timeout = ^PLAY_TIMEOUT;
    assign w_play_timeout        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b1;
            ok1_q       <= 1'b0;
            ok2_q       <= 1'b0;
            round_q     <= 4'd0;
            score1_q    <= '0;
            score2_q    <= '0;
            game_over_q <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= START;
            ok1_q       <= ok1_d;
            ok2_q       <= ok2_d;
            round_q     <= round_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            game_over_q <= game_over_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_start_rise) state_d = ST_READY;
            ST_READY:  if (w_ready_go) state_d = ST_PLAY;
            ST_PLAY:   if (w_any_win || w_play_timeout) state_d = ST_RESULT;
            ST_RESULT: if (w_result_done) state_d = w_last_round ? ST_IDLE : ST_READY;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Ready flags are only live inside READY, so they are clear whenever READY is entered.
    always_comb begin
        ok1_d       = 1'b0;
        ok2_d       = 1'b0;
        round_d     = round_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        game_over_d = game_over_q;
        led_d       = (state_d == ST_RESULT);
        case (state_q)
            ST_IDLE: begin
                if (w_start_rise) begin
                    round_d     = 4'd1;
                    score1_d    = '0;
                    score2_d    = '0;
                    game_over_d = 1'b0;
                end
            end
            ST_READY: begin
                ok1_d = ok1_q || OK;
                ok2_d = ok2_q || OK_2;
            end
            ST_PLAY: begin
                if (WIN_1P && !WIN_2P && (score1_q != {SCORE_W{1'b1}})) begin
                    score1_d = score1_q + SCORE_W'(1);
                end
                if (WIN_2P && !WIN_1P && (score2_q != {SCORE_W{1'b1}})) begin
                    score2_d = score2_q + SCORE_W'(1);
                end
            end
            ST_RESULT: begin
                if (w_result_done) begin
                    if (w_last_round) begin
                        round_d     = 4'd0;
                        game_over_d = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign STATE     = state_q;
    assign ROUND     = round_q;
    assign SCORE_1P  = score1_q;
    assign SCORE_2P  = score2_q;
    assign GAME_OVER = game_over_q;
    assign LED       = led_q;

endmodule

`default_nettype wire

// File: doc/game_state_ctrl.md
# game_state_ctrl

Master sequencer for the two-player factorization game. Drives the shared 4-bit `STATE` bus consumed by the ready, question and judge blocks, and advances on their completion handshakes (`OK`/`OK_2` from the ready block, win pulses from the judge). Also keeps the round count and both players' scores. This block produces `STATE` and consumes `OK`/`OK_2`; the ready block does the reverse.

## Interface
Parameters:
- `ROUNDS`, 5: rounds per game (1..15)
- `RESULT_CYCLES`, 1024: cycles the RESULT state is held
- `PLAY_TIMEOUT`, 65536: PLAY state cycle limit (used only with the macro)
- `SCORE_W`, 4: score counter width

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  asynchronous, active-low reset
- `START`  in  1  start button, level, synchronized upstream
- `OK`  in  1  player 1 ready confirm (level)
- `OK_2`  in  1  player 2 ready confirm (level)
- `WIN_1P`  in  1  judge: player 1 answered correctly, 1-cycle pulse
- `WIN_2P`  in  1  judge: player 2 answered correctly, 1-cycle pulse
- `STATE`  out  4  one-hot game state
- `ROUND`  out  4  current round, 1-based, 0 in IDLE
- `SCORE_1P`  out  SCORE_W  player 1 score
- `SCORE_2P`  out  SCORE_W  player 2 score
- `GAME_OVER`  out  1  high in IDLE after a completed game until next START
- `LED`  out  1  high while in RESULT

## Operation
- State encoding: IDLE 4'b0001, READY 4'b0010, PLAY 4'b0100, RESULT 4'b1000. Any other value of the state register goes to IDLE on the next clock.
- IDLE -> READY on a rising edge of `START`. On this transition: `ROUND`=1, scores cleared, `GAME_OVER` cleared.
- READY:
  - `OK` and `OK_2` are latched into sticky flags, so they may arrive in different cycles.
  - Go to PLAY in the cycle after both flags are set. Both inputs high in the same cycle counts.
  - Both flags clear on entry to READY.
- PLAY -> RESULT on `WIN_1P` or `WIN_2P`.
  - Only `WIN_1P`: `SCORE_1P`+1.
  - Only `WIN_2P`: `SCORE_2P`+1.
  - Both in the same cycle: tie, neither score changes.
  - Scores saturate at 2^SCORE_W-1.
  - Win pulses outside PLAY are ignored.
- RESULT: `LED`=1. After `RESULT_CYCLES` cycles:
  - if `ROUND` < `ROUNDS`: `ROUND`+1, go to READY;
  - otherwise: go to IDLE with `GAME_OVER`=1. `ROUND`=0 and scores are held for display.
- `START` is ignored outside IDLE.

## Timing
- Reset (`RST`=0, asynchronous): `STATE`=4'b0001, `ROUND`=0, scores=0, `GAME_OVER`=0, `LED`=0, ready flags cleared, timers cleared. Reset mid-game abandons the game immediately.
- All outputs are registered. `STATE` changes on the first clock edge after the qualifying input is sampled high (1-cycle latency).
- Score update and `STATE`=RESULT appear on the same edge.
- RESULT dwell is exactly `RESULT_CYCLES` cycles. The counter loads 0 on entry, and exit happens on the edge where the count equals `RESULT_CYCLES`-1.
- `START` edge detect uses one internal register. That register is reset to 1, so a button held through reset does not start a game.

## Configuration
- `PLAY_TIMEOUT_EN` defined:
  - A PLAY cycle counter runs.
  - After `PLAY_TIMEOUT` cycles with no win, go to RESULT with no score change.
  - A win pulse in the timeout cycle takes priority and scores normally.
- Not defined:
  - No counter is built; PLAY waits indefinitely for a win pulse.
  - `PLAY_TIMEOUT` is unused.

## Structure
- `game_pkg`: state encoding localparams (`ST_IDLE`, `ST_READY`, `ST_PLAY`, `ST_RESULT`), `STATE_W`=4.
- One sub-module, `dwell_timer`:
  - Parameterized terminal count, clear-on-entry input, `done` pulse output.
  - Instantiated for RESULT and, under the macro, for PLAY.
- The top level holds the FSM, ready flags, edge detect, round and score registers.

## Test plan
Bench parameters: `RESULT_CYCLES`=4, `ROUNDS`=2 unless noted.
- Reset then `START` 0->1: `STATE` 0001 -> 0010 one cycle after the edge, `ROUND`=1, scores 0.
- `OK`=1 at cycle 5, `OK_2`=1 at cycle 10: `STATE`=0100 at cycle 11. Repeat with both raised at cycle 5: PLAY at cycle 6.
- `WIN_1P` pulse in PLAY: `SCORE_1P`=1, `STATE`=1000, `LED`=1 for exactly 4 cycles, then READY with `ROUND`=2. `WIN_1P` and `WIN_2P` pulsed together: both scores unchanged.
- Second round ends with `WIN_2P`: IDLE, `GAME_OVER`=1, scores 1/1, `ROUND`=0. `START` held high produces no restart until released and re-pressed.
- Pull `RST` low mid-PLAY, asynchronously between edges: all outputs at reset values before the next edge. With `START` held high through reset release, `STATE` stays 0001.
- With `PLAY_TIMEOUT_EN` and `PLAY_TIMEOUT`=8, no win pulse: RESULT after 8 PLAY cycles, scores unchanged. `WIN_1P` in cycle 8: `SCORE_1P`+1.
